// File: rtl/setpoint_ramp.sv
// setpoint_ramp: rate-limited ramp of Out toward Target; define SETPOINT_RAMP_LIMIT_EN to clamp Target to +/-Limit
module setpoint_ramp #(
  parameter logic [15:0] INIT_VALUE = 16'sd0,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [15:0]          target_i,
  input  logic [15:0]          step_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic [15:0]          limit_i,
  output logic [15:0]          out_o,
  output logic                 busy_o,
  output logic                 at_target_o,
  output logic                 strobe_o
);
  localparam logic IDLE = 1'b0;
  localparam logic RAMP = 1'b1;
  logic                 state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          out_q, out_d, et, stepped;
  logic                 busy_q, at_q, strobe_q, tick;
  logic [16:0]          diff, mag;
`ifdef SETPOINT_RAMP_LIMIT_EN
  logic [15:0] lim, neg_lim;
  assign lim     = limit_i[15] ? 16'h7fff : limit_i;
  assign neg_lim = -lim;
  assign et = $signed(target_i) > $signed(lim) ? lim :
              $signed(target_i) < $signed(neg_lim) ? neg_lim : target_i;
`else
  logic unused_limit;
  assign unused_limit = ^limit_i;
  assign et = target_i;
`endif
  // 17-bit distance keeps full-scale swings exact, so the final step can land on ET without wrapping
  assign diff    = {et[15], et} - {out_q[15], out_q};
  assign mag     = diff[16] ? -diff : diff;
  assign stepped = mag <= {1'b0, step_i} ? et : diff[16] ? out_q - step_i : out_q + step_i;
  assign tick    = state_q == RAMP && cnt_q == divider_i;
  // next state: disable freezes, zero step bypasses, otherwise step toward ET on each prescaler tick
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    out_d   = out_q;
    if (!enable_i) state_d = IDLE;
    else if (step_i == '0) begin
      out_d   = et;
      state_d = IDLE;
    end else if (state_q == IDLE) state_d = out_q != et ? RAMP : IDLE;
    else if (tick) begin
      out_d   = stepped;
      state_d = stepped == et ? IDLE : RAMP;
    end else cnt_d = cnt_q + 1'b1;
  end
  // state and registered status flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= INIT_VALUE;
      busy_q   <= 1'b0;
      at_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= enable_i && step_i != '0 && out_q != et;
      at_q     <= out_q == et;
      strobe_q <= out_d != out_q;
    end
  end
  assign out_o       = out_q;
  assign busy_o      = busy_q;
  assign at_target_o = at_q;
  assign strobe_o    = strobe_q;
endmodule

// File: tb/tb_setpoint_ramp.sv
// tb_setpoint_ramp: vector table, directed corner sequences and random stimulus against a reference model
module tb_setpoint_ramp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, en = 1'b0;
  logic [15:0] tgt = '0, stp = '0, div = '0, lim = '0;
  logic [15:0] out;
  logic busy, at_tgt, strobe;
  int checks = 0, errors = 0;
  bit mdl_on = 1'b0;
  int m_out = 0, m_cnt = 0, m_busy = 0, m_at = 0, m_strobe = 0;
  bit m_ramp = 1'b0;

  setpoint_ramp dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .target_i(tgt), .step_i(stp),
    .divider_i(div), .limit_i(lim), .out_o(out), .busy_o(busy),
    .at_target_o(at_tgt), .strobe_o(strobe)
  );

  function automatic int outv();
    return int'($signed(out));
  endfunction

  function automatic int et_f();
    int t;
    t = int'($signed(tgt));
`ifdef SETPOINT_RAMP_LIMIT_EN
    begin
      int l;
      l = int'(lim) > 32767 ? 32767 : int'(lim);
      t = t > l ? l : (t < -l ? -l : t);
    end
`endif
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // reference model: Out moves toward the effective target by at most Step per tick
  always @(posedge clk) begin
    int e, n_out, d, s;
    e = et_f();
    s = int'(stp);
    n_out = m_out;
    if (rst) begin
      m_out = 0; m_ramp = 0; m_cnt = 0; m_busy = 0; m_at = 0; m_strobe = 0;
    end else begin
      m_busy = (en && s != 0 && m_out != e) ? 1 : 0;
      m_at = (m_out == e) ? 1 : 0;
      if (!en) begin
        m_ramp = 0; m_cnt = 0;
      end else if (s == 0) begin
        n_out = e; m_ramp = 0; m_cnt = 0;
      end else if (!m_ramp) begin
        m_ramp = (m_out != e); m_cnt = 0;
      end else if (m_cnt == int'(div)) begin
        d = e - m_out;
        n_out = (d >= -s && d <= s) ? e : (d > 0 ? m_out + s : m_out - s);
        m_cnt = 0;
        m_ramp = (n_out != e);
      end else m_cnt++;
      m_strobe = (n_out != m_out) ? 1 : 0;
      m_out = n_out;
    end
  end

  always @(negedge clk) if (mdl_on) begin
    checks++;
    if (outv() != m_out || int'(busy) != m_busy || int'(at_tgt) != m_at || int'(strobe) != m_strobe) begin
      errors++;
      $display("FAIL model out/busy/at/strobe actual %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
               outv(), busy, at_tgt, strobe, m_out, m_busy, m_at, m_strobe);
    end
  end

  typedef struct {
    bit r, e; int t, s, dv;
    int x_out, x_busy, x_strobe;
  } vec_t;
  vec_t vt[19];

  task automatic ramp_to_600();
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; tgt = 16'd1000; stp = 16'd300; div = 16'd3;
    repeat (9) @(negedge clk);
    chk("ramp_600", outv(), 600);
  endtask

  initial begin
    for (int i = 0; i < 19; i++) begin
      vt[i].r = (i == 0); vt[i].e = (i != 0); vt[i].t = 1000; vt[i].s = 300; vt[i].dv = 3;
      vt[i].x_out = i < 5 ? 0 : (i < 17 ? 300 * ((i - 1) / 4) : 1000);
      vt[i].x_busy = (i >= 1 && i <= 17) ? 1 : 0;
      vt[i].x_strobe = (i == 5 || i == 9 || i == 13 || i == 17) ? 1 : 0;
    end
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      rst = vt[i].r; en = vt[i].e; tgt = 16'(vt[i].t); stp = 16'(vt[i].s); div = 16'(vt[i].dv);
      @(negedge clk);
      if (i == 0) begin
        chk("reset_busy", int'(busy), 0);
        chk("reset_at", int'(at_tgt), 0);
        mdl_on = 1'b1;
      end
      chk($sformatf("vec%0d_out", i), outv(), vt[i].x_out);
      chk($sformatf("vec%0d_busy", i), int'(busy), vt[i].x_busy);
      chk($sformatf("vec%0d_strobe", i), int'(strobe), vt[i].x_strobe);
    end
    chk("settled_at", int'(at_tgt), 1);

    ramp_to_600();
    tgt = 16'd0;
    repeat (3) @(negedge clk);
    chk("rev_hold", outv(), 600);
    @(negedge clk);
    chk("rev_300", outv(), 300);
    repeat (4) @(negedge clk);
    chk("rev_0", outv(), 0);

    ramp_to_600();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_hold", outv(), 600);
    end
    chk("dis_busy", int'(busy), 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out", outv(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(strobe), 0);
    rst = 1'b0;

    stp = 16'd0; tgt = 16'd1234;
    @(negedge clk);
    chk("byp_1234", outv(), 1234);
    chk("byp_busy", int'(busy), 0);
    tgt = 16'hfffb;
    @(negedge clk);
    chk("byp_m5", outv(), -5);
    chk("byp_busy2", int'(busy), 0);

    tgt = 16'd32000;
    @(negedge clk);
    stp = 16'd1000; div = 16'd0; tgt = 16'h8000;
    begin
      int prev, ups, strobes, pre_last;
      bit done;
      prev = outv(); ups = 0; strobes = 0; pre_last = 0; done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clk);
        if (outv() > prev) ups++;
        strobes += int'(strobe);
        if (outv() == -32768) begin
          done = 1; pre_last = prev;
        end
        prev = outv();
      end
      chk("fs_reached", int'(done), 1);
      chk("fs_no_wrap", ups, 0);
      chk("fs_strobes", strobes, 65);
      chk("fs_pre_last", pre_last, -32000);
    end

    stp = 16'd0; lim = 16'd5000; tgt = 16'd20000;
    repeat (2) @(negedge clk);
`ifdef SETPOINT_RAMP_LIMIT_EN
    chk("lim_pos", outv(), 5000);
`else
    chk("lim_pos", outv(), 20000);
`endif
    chk("lim_at", int'(at_tgt), 1);
    tgt = 16'(-20000);
    repeat (2) @(negedge clk);
`ifdef SETPOINT_RAMP_LIMIT_EN
    chk("lim_neg", outv(), -5000);
`else
    chk("lim_neg", outv(), -20000);
`endif

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) tgt = 16'($urandom);
      if ($urandom_range(0, 39) == 0) lim = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 9000));
      if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)
        case ($urandom_range(0, 2))
          0: stp = 16'd0;
          1: stp = 16'($urandom_range(1, 500));
          default: stp = 16'($urandom_range(1, 40000));
        endcase
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
